cpu_controller: RTL and testbench



---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/cpu_decoder.sv | 63 ++++++
 rtl/cpu_controller.sv | 167 ++++++++++++++++
 tb/tb_cpu_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU sequencer.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP      = 4'h0,
    OP_LOAD     = 4'h1,
    OP_STORE    = 4'h2,
    OP_ADD      = 4'h3,
    OP_SUBT     = 4'h4,
    OP_HALT     = 4'h7,
    OP_SKIPCOND = 4'h8,
    OP_JUMP     = 4'h9,
    OP_CLEAR    = 4'hA
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_CAP,
    S_DECODE,
    S_MEM_RD,
    S_MEM_CAP,
    S_EXEC,
    S_MEM_WR,
    S_HALTED
  } state_e;

  // What DECODE has to do with the current instruction
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MEM_RD,
    CLS_STORE,
    CLS_HALT,
    CLS_SKIP,
    CLS_JUMP,
    CLS_CLEAR
  } op_class_e;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // SKIPCOND condition codes, IR[11:10]
  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

endpackage

// File: rtl/cpu_decoder.sv
// Opcode to control-class decode, ALU select and skip-condition evaluation.
// Macro CPU_CTRL_SUBT_EN: when defined, opcode 4 is SUBT; otherwise it is a NOP.
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [3:0]            opcode,
  input  logic [1:0]            cond,
  input  logic [DATA_WIDTH-1:0] ac,
  output op_class_e             op_class,
  output logic [1:0]            alu_sel,
  output logic                  use_alu,
  output logic                  skip
);

  logic ac_neg;
  logic ac_zero;

  assign ac_neg  = ac[DATA_WIDTH-1];
  assign ac_zero = (ac == '0);

  // Classify the opcode and pick the ALU function for arithmetic ops
  always_comb begin
    op_class = CLS_NOP;
    alu_sel  = ALU_PASS;
    use_alu  = 1'b0;
    case (opcode)
      OP_LOAD:     op_class = CLS_MEM_RD;
      OP_ADD: begin
        op_class = CLS_MEM_RD;
        alu_sel  = ALU_ADD;
        use_alu  = 1'b1;
      end
`ifdef CPU_CTRL_SUBT_EN
      OP_SUBT: begin
        op_class = CLS_MEM_RD;
        alu_sel  = ALU_SUB;
        use_alu  = 1'b1;
      end
`endif
      OP_STORE:    op_class = CLS_STORE;
      OP_HALT:     op_class = CLS_HALT;
      OP_SKIPCOND: op_class = CLS_SKIP;
      OP_JUMP:     op_class = CLS_JUMP;
      OP_CLEAR:    op_class = CLS_CLEAR;
      default:     op_class = CLS_NOP;
    endcase
  end

  // Signed test of AC against zero selected by the condition code
  always_comb begin
    skip = 1'b0;
    case (cond)
      SKIP_NEG:   skip = ac_neg;
      SKIP_ZERO:  skip = ac_zero;
      SKIP_POS:   skip = !ac_neg && !ac_zero;
      SKIP_NEVER: skip = 1'b0;
      default:    skip = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Macro CPU_CTRL_SUBT_EN: enables the SUBT instruction (opcode 4).
//
// state     | meaning
// IDLE      | waiting for start after reset
// FETCH     | PC driven to RAM with read strobe
// FETCH_CAP | instruction captured into IR, PC incremented
// DECODE    | opcode dispatch; single-cycle ops complete here
// MEM_RD    | operand address driven to RAM with read strobe
// MEM_CAP   | operand captured into MBR
// EXEC      | AC updated from MBR or ALU
// MEM_WR    | MBR written to RAM at MAR
// HALTED    | stopped; start restarts from RESET_PC
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [1:0]            alu_sel,
  input  logic [7:0]            alu_out,
  output logic                  busy,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic [DATA_WIDTH-1:0] ir
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mbr;
  logic [ADDR_WIDTH-1:0] operand;
  op_class_e             op_class;
  logic                  use_alu;
  logic                  skip;

  assign operand = ir[ADDR_WIDTH-1:0];

  cpu_decoder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decoder (
    .opcode  (ir[DATA_WIDTH-1 -: 4]),
    .cond    (ir[ADDR_WIDTH-1 -: 2]),
    .ac      (ac),
    .op_class(op_class),
    .alu_sel (alu_sel),
    .use_alu (use_alu),
    .skip    (skip)
  );

  // The fetch address comes straight from PC so the RAM read completes by FETCH_CAP
  assign mem_addr  = (state_q == S_FETCH) ? pc : mar;
  assign mem_wdata = mbr;
  assign alu_a     = ac[7:0];
  assign alu_b     = mbr[7:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and RAM strobe / status decode
  always_comb begin
    state_d = state_q;
    mem_cs  = 1'b0;
    mem_we  = 1'b0;
    mem_oe  = 1'b0;
    busy    = 1'b1;
    halted  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_cs  = 1'b1;
        mem_oe  = 1'b1;
        state_d = S_FETCH_CAP;
      end
      S_FETCH_CAP: state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CLS_MEM_RD: state_d = S_MEM_RD;
          CLS_STORE:  state_d = S_MEM_WR;
          CLS_HALT:   state_d = S_HALTED;
          default:    state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        mem_cs  = 1'b1;
        mem_oe  = 1'b1;
        state_d = S_MEM_CAP;
      end
      S_MEM_CAP: state_d = S_EXEC;
      S_EXEC:    state_d = S_FETCH;
      S_MEM_WR: begin
        mem_cs  = 1'b1;
        mem_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural register updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_PC;
      ir  <= '0;
      mar <= '0;
      mbr <= '0;
      ac  <= '0;
    end else begin
      case (state_q)
        S_FETCH: mar <= pc;
        S_FETCH_CAP: begin
          ir <= mem_rdata;
          pc <= pc + ADDR_WIDTH'(1);
        end
        S_DECODE: begin
          case (op_class)
            CLS_MEM_RD: mar <= operand;
            CLS_STORE: begin
              mar <= operand;
              mbr <= ac;
            end
            CLS_SKIP:  if (skip) pc <= pc + ADDR_WIDTH'(1);
            CLS_JUMP:  pc <= operand;
            CLS_CLEAR: ac <= '0;
            default: ;
          endcase
        end
        S_MEM_CAP: mbr <= mem_rdata;
        S_EXEC: begin
          if (use_alu) ac <= {{(DATA_WIDTH-8){1'b0}}, alu_out};
          else         ac <= mbr;
        end
        S_HALTED: begin
          if (start) begin
            pc <= RESET_PC;
            ac <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: RAM and ALU models, directed
// vectors, corner sequences and random programs against an ISA interpreter.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] mem_addr;
  logic        mem_cs, mem_we, mem_oe;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic        busy, halted;
  logic [11:0] pc;
  logic [15:0] ac, ir;

  int passed = 0;
  int total  = 0;
  int sub_sel_seen = 0;

  cpu_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .busy(busy), .halted(halted), .pc(pc), .ac(ac), .ir(ir)
  );

  always #5 clk = ~clk;

  // ALU model
  always_comb begin
    case (alu_sel)
      2'b01:   alu_out = alu_a + alu_b;
      2'b10:   alu_out = alu_a - alu_b;
      default: alu_out = alu_a;
    endcase
  end

  always @(negedge clk) if (alu_sel == 2'b10) sub_sel_seen++;

  // Synchronous RAM with a backdoor load port
  logic [15:0] ram [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr;
  logic [15:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr];
  end

  logic [15:0] ref_mem [0:4095];

`ifdef CPU_CTRL_SUBT_EN
  localparam logic [15:0] SUB53 = 16'h0002;
  localparam logic [15:0] SUB35 = 16'h00FE;
  localparam int          SUBCYC = 15;
`else
  localparam logic [15:0] SUB53 = 16'h0005;
  localparam logic [15:0] SUB35 = 16'h0003;
  localparam int          SUBCYC = 12;
`endif

  typedef struct {
    string       name;
    logic [15:0] a, b, instr, exp_ac, exp_202;
    logic [11:0] exp_pc;
    int          exp_cyc;
  } vec_t;

  function automatic vec_t mkv(string n, logic [15:0] a, logic [15:0] b, logic [15:0] ins,
                               logic [15:0] eac, logic [15:0] e202, logic [11:0] epc, int ecyc);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.instr = ins; v.exp_ac = eac;
    v.exp_202 = e202; v.exp_pc = epc; v.exp_cyc = ecyc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ref_mem[a] = d;
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Release reset and pulse start; returns with the CPU in its first FETCH
  task automatic launch();
    rst = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  // Instruction-level interpreter: final PC, AC and cycle count
  task automatic ref_run(output logic [11:0] fpc, output logic [15:0] fac, output int cyc);
    logic [11:0] rpc;
    logic [15:0] rac, ins, opv;
    bit done, sk;
    rpc = 12'h100; rac = '0; cyc = 0; done = 0;
    for (int step = 0; step < 2000 && !done; step++) begin
      ins = ref_mem[rpc];
      rpc = rpc + 12'd1;
      opv = ref_mem[ins[11:0]];
      case (ins[15:12])
        4'h1: begin rac = opv; cyc += 6; end
        4'h2: begin ref_mem[ins[11:0]] = rac; cyc += 4; end
        4'h3: begin rac = {8'h00, 8'(rac[7:0] + opv[7:0])}; cyc += 6; end
`ifdef CPU_CTRL_SUBT_EN
        4'h4: begin rac = {8'h00, 8'(rac[7:0] - opv[7:0])}; cyc += 6; end
`endif
        4'h7: begin cyc += 3; done = 1; end
        4'h8: begin
          case (ins[11:10])
            2'b00:   sk = $signed(rac) < 0;
            2'b01:   sk = (rac == 0);
            2'b10:   sk = $signed(rac) > 0;
            default: sk = 0;
          endcase
          if (sk) rpc = rpc + 12'd1;
          cyc += 3;
        end
        4'h9: begin rpc = ins[11:0]; cyc += 3; end
        4'hA: begin rac = '0; cyc += 3; end
        default: cyc += 3;
      endcase
    end
    fpc = rpc; fac = rac;
  endtask

  vec_t        vecs [19];
  logic [15:0] mult_prog [0:15];
  logic [3:0]  nop_ops [0:7];

  initial begin
    int          cyc, ecyc, bad, sel;
    logic [11:0] epc;
    logic [15:0] eac, w;

    vecs[0]  = mkv("add",        16'h0005, 16'h0003, 16'h3201, 16'h0008, 16'hDEAD, 12'h103, 15);
    vecs[1]  = mkv("add_wrap",   16'h00F0, 16'h0020, 16'h3201, 16'h0010, 16'hDEAD, 12'h103, 15);
    vecs[2]  = mkv("add_hibits", 16'h12F0, 16'hAB01, 16'h3201, 16'h00F1, 16'hDEAD, 12'h103, 15);
    vecs[3]  = mkv("subt",       16'h0005, 16'h0003, 16'h4201, SUB53,    16'hDEAD, 12'h103, SUBCYC);
    vecs[4]  = mkv("subt_under", 16'h0003, 16'h0005, 16'h4201, SUB35,    16'hDEAD, 12'h103, SUBCYC);
    vecs[5]  = mkv("clear",      16'h1234, 16'h0000, 16'hA000, 16'h0000, 16'hDEAD, 12'h103, 12);
    vecs[6]  = mkv("skip_pos_t", 16'h0001, 16'h0000, 16'h8800, 16'h0001, 16'hDEAD, 12'h104, 12);
    vecs[7]  = mkv("skip_neg_f", 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'hDEAD, 12'h103, 12);
    vecs[8]  = mkv("skip_neg_t", 16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'hDEAD, 12'h104, 12);
    vecs[9]  = mkv("skip_zero_t",16'h0000, 16'h0000, 16'h8400, 16'h0000, 16'hDEAD, 12'h104, 12);
    vecs[10] = mkv("skip_zero_f",16'h0001, 16'h0000, 16'h8400, 16'h0001, 16'hDEAD, 12'h103, 12);
    vecs[11] = mkv("skip_never0",16'h0000, 16'h0000, 16'h8C00, 16'h0000, 16'hDEAD, 12'h103, 12);
    vecs[12] = mkv("skip_never1",16'h8000, 16'h0000, 16'h8C00, 16'h8000, 16'hDEAD, 12'h103, 12);
    vecs[13] = mkv("skip_pos_f", 16'hFFFF, 16'h0000, 16'h8800, 16'hFFFF, 16'hDEAD, 12'h103, 12);
    vecs[14] = mkv("nop",        16'h0007, 16'h0000, 16'h5000, 16'h0007, 16'hDEAD, 12'h103, 12);
    vecs[15] = mkv("store",      16'h4321, 16'h0000, 16'h2202, 16'h4321, 16'h4321, 12'h103, 13);
    vecs[16] = mkv("load",       16'h0001, 16'hBEEF, 16'h1201, 16'hBEEF, 16'hDEAD, 12'h103, 15);
    vecs[17] = mkv("jump",       16'h0002, 16'h0000, 16'h9103, 16'h0002, 16'hDEAD, 12'h104, 12);
    vecs[18] = mkv("skip_lowbits",16'h0001,16'h0000, 16'h88FF, 16'h0001, 16'hDEAD, 12'h104, 12);

    mult_prog = '{16'h110C, 16'h210E, 16'h110D, 16'h310B, 16'h210D, 16'h110E, 16'h310F, 16'h210E,
                  16'h8400, 16'h9102, 16'h7000, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 16'hFFFF};
    nop_ops = '{4'h0, 4'h5, 4'h6, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", 32'(pc), 32'h100);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_ac", 32'(ac), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_ctl", 32'({mem_cs, mem_we, mem_oe}), 32'h0);
    check("rst_status", 32'({busy, halted}), 32'h0);

    // Reset in the middle of the second FETCH
    for (int k = 0; k < 16; k++) poke(12'h100 + 12'(k), mult_prog[k]);
    launch();
    repeat (6) @(posedge clk);
    #1;
    check("midfetch_pre_cs", 32'(mem_cs), 32'd1);
    check("midfetch_pre_pc", 32'(pc), 32'h101);
    rst = 1'b1;
    #1;
    check("midfetch_pc", 32'(pc), 32'h100);
    check("midfetch_cs", 32'(mem_cs), 32'd0);
    check("midfetch_busy", 32'(busy), 32'd0);
    check("midfetch_ac", 32'(ac), 32'd0);
    @(posedge clk); #1;

    // Multiply program
    for (int k = 0; k < 16; k++) poke(12'h100 + 12'(k), mult_prog[k]);
    ref_run(epc, eac, ecyc);
    launch();
    wait_halt(cyc);
    check("mult_product", 32'(ram[12'h10D]), 32'h0023);
    check("mult_pc", 32'(pc), 32'h10B);
    check("mult_ac", 32'(ac), 32'(eac));
    check("mult_cycles", 32'(cyc), 32'(ecyc));

    // JUMP lands exactly three cycles after FETCH
    rst = 1'b1;
    poke(12'h100, 16'h91F0);
    poke(12'h1F0, 16'h7000);
    launch();
    repeat (2) @(posedge clk);
    #1;
    check("jump_pc_mid", 32'(pc), 32'h101);
    @(posedge clk); #1;
    check("jump_pc", 32'(pc), 32'h1F0);
    check("jump_fetch_addr", 32'({mem_cs, mem_oe, mem_addr}), 32'({2'b11, 12'h1F0}));
    wait_halt(cyc);
    check("jump_halt_pc", 32'(pc), 32'h1F1);

    // PC wraps from 0xFFF to 0x000
    rst = 1'b1;
    poke(12'h100, 16'h9FFF);
    poke(12'hFFF, 16'h0000);
    poke(12'h000, 16'h7000);
    launch();
    repeat (3) @(posedge clk);
    #1;
    check("wrap_at_fff", 32'(pc), 32'hFFF);
    repeat (3) @(posedge clk);
    #1;
    check("wrap_to_000", 32'(pc), 32'h000);
    wait_halt(cyc);
    check("wrap_halt_pc", 32'(pc), 32'h001);

    // STORE abandoned by reset during its write cycle
    rst = 1'b1;
    poke(12'h202, 16'hDEAD);
    poke(12'h100, 16'h2202);
    launch();
    repeat (3) @(posedge clk);
    #1;
    check("store_we_pre", 32'({mem_cs, mem_we, mem_oe, mem_addr}), 32'({3'b110, 12'h202}));
    rst = 1'b1;
    #1;
    check("store_abort_ctl", 32'({mem_cs, mem_we}), 32'd0);
    @(posedge clk); #1;
    check("store_abort_ram", 32'(ram[12'h202]), 32'hDEAD);

    // Restart from HALTED
    poke(12'h200, 16'h0055);
    poke(12'h100, 16'h1200);
    poke(12'h101, 16'h7000);
    launch();
    wait_halt(cyc);
    check("restart_pre_ac", 32'(ac), 32'h55);
    check("restart_pre_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_pc", 32'(pc), 32'h100);
    check("restart_ac", 32'(ac), 32'h0);
    check("restart_status", 32'({busy, halted}), 32'b10);
    wait_halt(cyc);
    check("restart_cycles", 32'(cyc), 32'd9);

    // Directed single-instruction vectors: LOAD 200; <instr>; HALT
    for (int v = 0; v < 19; v++) begin
      rst = 1'b1;
      poke(12'h200, vecs[v].a);
      poke(12'h201, vecs[v].b);
      poke(12'h202, 16'hDEAD);
      poke(12'h100, 16'h1200);
      poke(12'h101, vecs[v].instr);
      for (int k = 2; k < 5; k++) poke(12'h100 + 12'(k), 16'h7000);
      launch();
      wait_halt(cyc);
      check({vecs[v].name, "_ac"}, 32'(ac), 32'(vecs[v].exp_ac));
      check({vecs[v].name, "_pc"}, 32'(pc), 32'(vecs[v].exp_pc));
      check({vecs[v].name, "_ram"}, 32'(ram[12'h202]), 32'(vecs[v].exp_202));
      check({vecs[v].name, "_cycles"}, 32'(cyc), 32'(vecs[v].exp_cyc));
    end

    // Random forward-only programs against the interpreter
    for (int p = 0; p < 20; p++) begin
      rst = 1'b1;
      for (int k = 0; k < 16; k++) poke(12'h200 + 12'(k), 16'($urandom));
      for (int i = 0; i < 12; i++) begin
        sel = $urandom_range(8, 0);
        case (sel)
          0, 8: w = {4'h1, 12'h200 + 12'($urandom_range(15, 0))};
          1:    w = {4'h2, 12'h200 + 12'($urandom_range(15, 0))};
          2:    w = {4'h3, 12'h200 + 12'($urandom_range(15, 0))};
          3:    w = {4'h4, 12'h200 + 12'($urandom_range(15, 0))};
          4:    w = {4'h8, 2'($urandom_range(3, 0)), 10'($urandom)};
          5:    w = {4'h9, 12'h100 + 12'($urandom_range(12, i + 1))};
          6:    w = {4'hA, 12'($urandom)};
          default: w = {nop_ops[$urandom_range(7, 0)], 12'($urandom)};
        endcase
        poke(12'h100 + 12'(i), w);
      end
      poke(12'h10C, 16'h7000);
      poke(12'h10D, 16'h7000);
      ref_run(epc, eac, ecyc);
      launch();
      wait_halt(cyc);
      check("rand_ac", 32'(ac), 32'(eac));
      check("rand_pc", 32'(pc), 32'(epc));
      check("rand_cycles", 32'(cyc), 32'(ecyc));
      bad = 0;
      for (int k = 0; k < 16; k++)
        if (ram[12'h200 + 12'(k)] !== ref_mem[12'h200 + 12'(k)]) bad++;
      check("rand_ram", 32'(bad), 32'd0);
    end

`ifdef CPU_CTRL_SUBT_EN
    check("alu_sub_used", 32'(sub_sel_seen > 0), 32'd1);
`else
    check("alu_sub_absent", 32'(sub_sel_seen), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
